// File: rtl/regfile_1r1w_arb_pkg.sv
// Shared types and default sizes for the two-client 1R1W register-file scheduler.
package regfile_arb_pkg;

    localparam int AW_DEF    = 7;
    localparam int DW_DEF    = 13;
    localparam int DEPTH_DEF = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_t;

endpackage

// File: rtl/regfile_1r1w_arb_if.sv
// Client-side request/response bundle; bit index N of every field belongs to client N.
interface regfile_1r1w_arb_if
    import regfile_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [1:0]         wr_valid;
    logic [1:0]         wr_ready;
    logic [1:0][AW-1:0] wr_addr;
    logic [1:0][DW-1:0] wr_data;
    logic [1:0]         rd_valid;
    logic [1:0]         rd_ready;
    logic [1:0][AW-1:0] rd_addr;
    logic [1:0]         rsp_valid;
    logic [1:0][DW-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on contention the pointed-to requester wins
// and the pointer moves to the loser when advance_i is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = req_i;
        ptr_d = ptr_q;
        if (&req_i) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
            if (advance_i) begin
                ptr_d = ~ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/regfile_1r1w_arb.sv
// Shares one 1R1W register file between two clients: zero-fill after reset, then one
// round-robin grant per cycle with same-address reads riding along on writes.
module regfile_1r1w_arb
    import regfile_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_1r1w_arb_if.slave bus,
    output logic              rf_we_o,
    output logic [AW-1:0]     rf_waddr_o,
    output logic [DW-1:0]     rf_din_o,
    output logic [AW-1:0]     rf_raddr_o,
    input  logic [DW-1:0]     rf_q_i,
    output logic              init_done_o
);
    localparam int CW = AW + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] init_cnt_q, init_cnt_d;
    logic          init_arm_q;
    logic          init_done_q, init_done_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;

    logic [1:0]    eligible;
    logic [1:0]    arb_gnt;
    logic          rr_ptr;
    logic          arb_adv;
    logic          win;
    op_t           op;
    logic [1:0]    wr_ready;
    logic [1:0]    rd_ready;

    assign eligible = bus.wr_valid | bus.rd_valid;
    assign arb_adv  = (state_q == RUN);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (eligible),
        .advance_i (arb_adv),
        .gnt_o     (arb_gnt),
        .ptr_o     (rr_ptr)
    );

    // Grant and register-file drive. A read may only share a cycle with a write to the
    // same address, because the register file returns din while we is high.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        win        = arb_gnt[1];
        op         = OP_NONE;
        wr_ready   = '0;
        rd_ready   = '0;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_din_o   = '0;
        raddr_d    = raddr_q;

        if (state_q == RUN && |eligible) begin
            op = bus.wr_valid[win] ? OP_WR : OP_RD;
        end

        case (op)
            OP_WR: begin
                rf_we_o       = 1'b1;
                rf_waddr_o    = bus.wr_addr[win];
                rf_din_o      = bus.wr_data[win];
                wr_ready[win] = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    if (bus.rd_valid[c] && bus.rd_addr[c] == bus.wr_addr[win]) begin
                        rd_ready[c] = 1'b1;
                        raddr_d     = bus.wr_addr[win];
                    end
                end
            end
            OP_RD: begin
                rd_ready[win] = 1'b1;
                raddr_d       = bus.rd_addr[win];
            end
            default: begin
                // NOTE: the register file has no reset of its own; it is cleared by this fill.
                if (state_q == INIT) begin
                    rf_we_o    = init_arm_q;
                    rf_waddr_o = init_cnt_q[AW-1:0];
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                if (init_arm_q) begin
                    init_cnt_d = init_cnt_q + CW'(1);
                    if (init_cnt_q == CW'(DEPTH - 1)) begin
                        state_d     = RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign rsp_valid_d = bus.rd_valid & rd_ready;

    // init_arm_q keeps rf_we low while reset is held and opens the fill on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_arm_q  <= 1'b0;
            init_done_q <= 1'b0;
            raddr_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_arm_q  <= 1'b1;
            init_done_q <= init_done_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rf_raddr_o    = raddr_d;
    assign init_done_o   = init_done_q;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_ready  = rd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = {rf_q_i, rf_q_i};

    // Under contention the arbiter must honour its pointer.
    assert property (@(posedge clk) disable iff (!rst_n) (&eligible) |-> arb_gnt[rr_ptr]);
endmodule

// File: tb/tb_regfile_1r1w_arb.sv
// Bench for regfile_1r1w_arb: register-file model, vector table, directed corner cases
// and random traffic checked against a request-level scoreboard.
module tb_regfile_1r1w_arb;
    import regfile_arb_pkg::*;

    localparam int AW    = AW_DEF;
    localparam int DW    = DW_DEF;
    localparam int DEPTH = DEPTH_DEF;

    typedef struct {
        logic [1:0]         wv;
        logic [1:0]         rv;
        logic [1:0][AW-1:0] wa;
        logic [1:0][AW-1:0] ra;
        logic [1:0][DW-1:0] wd;
    } req_t;

    typedef struct {
        req_t       r;
        logic [1:0] exp_wr;
        logic [1:0] exp_rd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_q;
    logic          init_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_1r1w_arb_if #(.AW(AW), .DW(DW)) bus ();

    regfile_1r1w_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_din_o    (rf_din),
        .rf_raddr_o  (rf_raddr),
        .rf_q_i      (rf_q),
        .init_done_o (init_done)
    );

    // 1R1W register file: registered read, din forwarded while we is high, nonzero garbage at start.
    logic [DW-1:0] rf_mem [2**AW];
    logic          seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 2**AW; i++) rf_mem[i] <= DW'(32'h0AAA ^ i);
            seeded <= 1'b1;
            rf_q   <= '1;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_din;
            rf_q             <= rf_din;
        end else begin
            rf_q <= rf_mem[rf_raddr];
        end
    end

    // Scoreboard state: round-robin favourite and expected register-file contents.
    int            ptr_m;
    logic [DW-1:0] mem_m [DEPTH];
    logic [1:0]    obs_wr, obs_rd, obs_rsp_v;
    logic [DW-1:0] obs_rsp_d [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t idle_req();
        req_t r;
        r.wv = '0; r.rv = '0; r.wa = '0; r.ra = '0; r.wd = '0;
        return r;
    endfunction

    function automatic req_t add_wr(input req_t r_in, input int c, input int a, input int d);
        req_t r = r_in;
        r.wv[c] = 1'b1; r.wa[c] = AW'(a); r.wd[c] = DW'(d);
        return r;
    endfunction

    function automatic req_t add_rd(input req_t r_in, input int c, input int a);
        req_t r = r_in;
        r.rv[c] = 1'b1; r.ra[c] = AW'(a);
        return r;
    endfunction

    task automatic drive(input req_t r);
        bus.wr_valid = r.wv; bus.wr_addr = r.wa; bus.wr_data = r.wd;
        bus.rd_valid = r.rv; bus.rd_addr = r.ra;
    endtask

    task automatic model_reset();
        ptr_m = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // Who should be granted this cycle, from the arbitration rules alone.
    task automatic model_grant(input req_t r, output logic [1:0] ewr, output logic [1:0] erd,
                               output int win, output bit both);
        bit e0, e1;
        e0 = r.wv[0] | r.rv[0];
        e1 = r.wv[1] | r.rv[1];
        ewr = '0; erd = '0; win = -1;
        both = e0 && e1;
        if (both) win = ptr_m;
        else if (e0) win = 0;
        else if (e1) win = 1;
        if (win >= 0) begin
            if (r.wv[win]) begin
                ewr[win] = 1'b1;
                for (int c = 0; c < 2; c++)
                    if (r.rv[c] && r.ra[c] == r.wa[win]) erd[c] = 1'b1;
            end else begin
                erd[win] = 1'b1;
            end
        end
    endtask

    // One RUN cycle: called at a negedge, returns at the next negedge.
    task automatic step(input req_t r, output logic [1:0] ewr, output logic [1:0] erd);
        int            win;
        bit            both;
        logic [1:0]    exp_v;
        logic [DW-1:0] exp_d [2];
        drive(r);
        #1;
        model_grant(r, ewr, erd, win, both);
        obs_wr = bus.wr_ready;
        obs_rd = bus.rd_ready;
        check("wr_ready", 32'(obs_wr), 32'(ewr));
        check("rd_ready", 32'(obs_rd), 32'(erd));
        check("rf_we", 32'(rf_we), 32'(|ewr));
        @(posedge clk);
        if (both) ptr_m = 1 - win;
        if (|ewr) mem_m[r.wa[win]] = r.wd[win];
        for (int c = 0; c < 2; c++) begin
            exp_v[c] = erd[c];
            exp_d[c] = erd[c] ? mem_m[r.ra[c]] : 'x;
        end
        #1;
        obs_rsp_v = bus.rsp_valid;
        for (int c = 0; c < 2; c++) obs_rsp_d[c] = bus.rsp_data[c];
        check("rsp_valid", 32'(obs_rsp_v), 32'(exp_v));
        for (int c = 0; c < 2; c++)
            if (exp_v[c]) check($sformatf("rsp_data_c%0d", c), 32'(obs_rsp_d[c]), 32'(exp_d[c]));
        @(negedge clk);
    endtask

    // Called at the negedge where rst_n is released; returns at a negedge in RUN.
    task automatic wait_init(input string tag);
        int cycles = 0;
        bit done = 0;
        while (!done && cycles < 4 * DEPTH) begin
            @(posedge clk);
            cycles++;
            #1;
            if (init_done) begin
                done = 1;
                drive(idle_req());
            end else begin
                check({tag, "_ready_in_init"}, 32'({bus.wr_ready, bus.rd_ready}), 32'(0));
                if (cycles <= DEPTH) begin
                    check({tag, "_init_we"}, 32'(rf_we), 32'(1));
                    check({tag, "_init_waddr"}, 32'(rf_waddr), 32'(cycles - 1));
                    check({tag, "_init_din"}, 32'(rf_din), 32'(0));
                end
            end
        end
        check({tag, "_init_done_cycle"}, 32'(cycles), 32'(DEPTH + 1));
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t       r;
        logic [1:0] gw, gr, prev;
        logic [1:0] pw, pr;
        logic [1:0][AW-1:0] pwa, pra;
        logic [1:0][DW-1:0] pwd;
        vec_t       vecs [11];

        // Reset state, with requests already asserted.
        model_reset();
        drive(add_rd(add_wr(idle_req(), 0, 2, 'h77), 1, 5));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_ready", 32'({bus.wr_ready, bus.rd_ready}), 32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_rf_we", 32'(rf_we), 32'(0));
        check("rst_rf_waddr", 32'(rf_waddr), 32'(0));
        check("rst_rf_din", 32'(rf_din), 32'(0));
        check("rst_rf_raddr", 32'(rf_raddr), 32'(0));
        rst_n = 1'b1;
        wait_init("boot");

        // Zero-filled entry reads back as 0.
        step(add_rd(idle_req(), 0, 5), gw, gr);
        check("d1_rsp_zero", 32'(obs_rsp_d[0]), 32'(0));

        // Write then read on client 0.
        step(add_wr(idle_req(), 0, 3, 'h1A5), gw, gr);
        check("d2_wr_ready_t", 32'(obs_wr), 32'(2'b01));
        step(add_rd(idle_req(), 0, 3), gw, gr);
        check("d2_rd_ready_t1", 32'(obs_rd), 32'(2'b01));
        check("d2_rsp_valid_t2", 32'(obs_rsp_v), 32'(2'b01));
        check("d2_rsp_data_t2", 32'(obs_rsp_d[0]), 32'('h1A5));

        // Both clients write continuously: grants alternate starting with client 0.
        r = add_wr(add_wr(idle_req(), 0, 1, 'h111), 1, 2, 'h222);
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            step(r, gw, gr);
            if (i == 0) check("d3_first_c0", 32'(obs_wr), 32'(2'b01));
            else        check("d3_alternate", 32'(obs_wr), 32'({prev[0], prev[1]}));
            prev = obs_wr;
        end
        step(add_rd(idle_req(), 0, 1), gw, gr);
        check("d3_addr1", 32'(obs_rsp_d[0]), 32'('h111));
        step(add_rd(idle_req(), 1, 2), gw, gr);
        check("d3_addr2", 32'(obs_rsp_d[1]), 32'('h222));

        // Same-address read piggybacks on the other client's write.
        step(add_rd(add_wr(idle_req(), 0, 4, 'h0FF), 1, 4), gw, gr);
        check("d4_wr", 32'(obs_wr), 32'(2'b01));
        check("d4_rd", 32'(obs_rd), 32'(2'b10));
        check("d4_rsp_data", 32'(obs_rsp_d[1]), 32'('h0FF));

        // Preload addr 9; the contention here also brings the favourite back to client 0.
        step(add_wr(add_wr(idle_req(), 0, 10, 'h0BB), 1, 9, 'h055), gw, gr);
        step(add_wr(idle_req(), 0, 10, 'h0BB), gw, gr);

        // Different-address read waits for the next cycle and sees the old data.
        step(add_rd(add_wr(idle_req(), 0, 4, 'h1ABC), 1, 9), gw, gr);
        check("d5_wr_only", 32'(obs_wr), 32'(2'b01));
        check("d5_no_rd", 32'(obs_rd), 32'(2'b00));
        step(add_rd(idle_req(), 1, 9), gw, gr);
        check("d5_rd_next", 32'(obs_rd), 32'(2'b10));
        check("d5_rsp_data", 32'(obs_rsp_d[1]), 32'('h055));

        // Vector table, applied back to back; client 1 is favoured at entry.
        vecs[0]  = '{add_wr(add_wr(idle_req(), 0, 6, 'h101), 1, 7, 'h202), 2'b10, 2'b00};
        vecs[1]  = '{add_wr(add_wr(idle_req(), 0, 6, 'h101), 1, 7, 'h202), 2'b01, 2'b00};
        vecs[2]  = '{add_rd(add_rd(idle_req(), 0, 6), 1, 7), 2'b00, 2'b10};
        vecs[3]  = '{add_rd(add_wr(idle_req(), 0, 8, 'h333), 0, 8), 2'b01, 2'b01};
        vecs[4]  = '{add_wr(add_rd(idle_req(), 0, 7), 1, 7, 'h404), 2'b00, 2'b01};
        vecs[5]  = '{add_wr(add_rd(idle_req(), 0, 2), 1, 2, 'h0AB), 2'b10, 2'b01};
        vecs[6]  = '{add_rd(add_rd(add_wr(idle_req(), 0, 5, 'h1FFF), 0, 5), 1, 5), 2'b01, 2'b11};
        vecs[7]  = '{idle_req(), 2'b00, 2'b00};
        vecs[8]  = '{add_rd(idle_req(), 1, 0), 2'b00, 2'b10};
        vecs[9]  = '{add_rd(add_wr(idle_req(), 0, 3, 'h042), 0, 9), 2'b01, 2'b00};
        vecs[10] = '{add_rd(idle_req(), 0, 9), 2'b00, 2'b01};
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, gw, gr);
            check($sformatf("vec%0d_wr", i), 32'(obs_wr), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_rd", i), 32'(obs_rd), 32'(vecs[i].exp_rd));
        end

        // Random traffic: requests are held until the scoreboard says they were granted.
        pw = '0; pr = '0; pwa = '0; pra = '0; pwd = '0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pw[c] && $urandom_range(0, 2) == 0) begin
                    pw[c]  = 1'b1;
                    pwa[c] = AW'($urandom_range(0, 7));
                    pwd[c] = DW'($urandom);
                end
                if (!pr[c] && $urandom_range(0, 2) == 0) begin
                    pr[c]  = 1'b1;
                    pra[c] = AW'($urandom_range(0, 7));
                end
            end
            r.wv = pw; r.rv = pr; r.wa = pwa; r.ra = pra; r.wd = pwd;
            step(r, gw, gr);
            pw = pw & ~gw;
            pr = pr & ~gr;
        end
        drive(idle_req());

        // Reset pulse while client 1 has a response in flight.
        step(add_wr(idle_req(), 1, 11, 'h1357), gw, gr);
        drive(add_rd(idle_req(), 1, 11));
        #1;
        check("mr_rd_granted", 32'(bus.rd_ready), 32'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_ready_drop", 32'({bus.wr_ready, bus.rd_ready}), 32'(0));
        check("mr_init_done_drop", 32'(init_done), 32'(0));
        drive(idle_req());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mr_rsp_discarded", 32'(bus.rsp_valid), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("rerun");
        step(add_rd(idle_req(), 1, 11), gw, gr);
        check("mr_refill_zero", 32'(obs_rsp_d[1]), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
